// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: sequential AES-128 key schedule storing all 11 round keys.
// Define KEY_EXP_ZEROIZE_EN to add a synchronous zeroize input that wipes the key store.

module key_generation (
  input  logic [3:0]   rc,
  input  logic [127:0] in_key,
  output logic [127:0] out_key
);
  // Byte b lives at SBOX[8*(255-b) +: 8], i.e. entry 0x00 is the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] w4, w5, w6, w7;
  logic [7:0]  rcon;

  always_comb begin
    rcon = 8'h00;
    case (rc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {w0, w1, w2, w3} = in_key;
  assign rot_w  = {w3[23:0], w3[31:24]};
  assign sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
  assign temp_w = sub_w ^ {rcon, 24'h000000};
  assign w4     = w0 ^ temp_w;
  assign w5     = w4 ^ w1;
  assign w6     = w5 ^ w2;
  assign w7     = w6 ^ w3;
  assign out_key = {w4, w5, w6, w7};
endmodule

module key_expansion_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter bit RD_REG     = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
`ifdef KEY_EXP_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $fatal(1, "key_expansion_ctrl supports only NUM_ROUNDS = 10 (AES-128)");
  end

  logic [1:0]   state_q, state_d;
  logic [3:0]   rc_cnt_q, rc_cnt_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  logic [127:0] gen_in, gen_out;
  logic [127:0] rd_key_d;
  logic         zero_req;
  logic         accept;

`ifdef KEY_EXP_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign key_ready  = ((state_q == IDLE) || (state_q == DONE)) && !zero_req;
  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == DONE);
  assign accept     = key_valid && key_ready;

  // The generator always works on the previous round key; rc_cnt is 1..10 in EXPAND.
  always_comb begin
    gen_in = '0;
    for (int i = 0; i < 10; i++) begin
      if (rc_cnt_q == 4'(i + 1)) gen_in = rk_q[i];
    end
  end

  key_generation u_keygen (
    .rc      (rc_cnt_q),
    .in_key  (gen_in),
    .out_key (gen_out)
  );

  always_comb begin
    state_d  = state_q;
    rc_cnt_d = rc_cnt_q;
    rk_d     = rk_q;
    if (zero_req) begin
      state_d  = IDLE;
      rc_cnt_d = 4'd0;
      for (int i = 0; i <= 10; i++) rk_d[i] = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            rk_d[0]  = key_in;
            rc_cnt_d = 4'd1;
            state_d  = EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= 10; i++) begin
            if (rc_cnt_q == 4'(i)) rk_d[i] = gen_out;
          end
          if (rc_cnt_q == LAST_RC) begin
            rc_cnt_d = 4'd0;
            state_d  = DONE;
          end else begin
            rc_cnt_d = rc_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d  = IDLE;
          rc_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rc_cnt_q <= 4'd0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rc_cnt_q <= rc_cnt_d;
      for (int i = 0; i <= 10; i++) rk_q[i] <= rk_d[i];
    end
  end

  // Indices 11..15 fall through to zero.
  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rd_round == 4'(i)) rd_key_d = rk_q[i];
    end
  end

  if (RD_REG) begin : g_rd_reg
    logic [127:0] rd_key_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_key_q <= '0;
      else        rd_key_q <= rd_key_d;
    end
    assign rd_key = rd_key_q;
  end else begin : g_rd_comb
    assign rd_key = rd_key_d;
  end
endmodule
